// File: rtl/l2_pkg.sv
// Shared definitions for the L2 fill controller: state encoding, line geometry and
// address-split helpers (byte offset 4 bits, then index, then tag).
package l2_pkg;

    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int OFFS_W         = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Ascending range so that word0 lands on bits [0:31] as the L1 expects.
    typedef logic [0:LINE_W-1] line_t;
    typedef logic [WORD_W-1:0] word_t;

    function automatic logic [1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[3:2];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_idx(input logic [ADDR_W-1:0] a, input int idx_w);
        return (a >> OFFS_W) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int idx_w);
        return a >> (OFFS_W + idx_w);
    endfunction

endpackage

// File: rtl/l2_fill_ctrl_if.sv
// L1-side request bundle and memory-side beat bundle for the L2 fill controller.
// "master" is the side that originates requests on each bundle.
interface l2_l1_if;
    import l2_pkg::*;

    logic [ADDR_W-1:0] req_addr;
    logic              req_ren;
    logic              req_wen;
    word_t             req_wdata;
    line_t             l1block;
    logic              stall_l2;

    modport master (output req_addr, req_ren, req_wen, req_wdata, input l1block, stall_l2);
    modport slave  (input req_addr, req_ren, req_wen, req_wdata, output l1block, stall_l2);
endinterface

interface l2_mem_if;
    import l2_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_wdata;
    logic              mem_ack;
    word_t             mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/l2_line_store.sv
// Tag/valid/data array of the direct-mapped L2: combinational read by index,
// synchronous whole-line or single-word write, valid bits cleared asynchronously.
module l2_line_store
    import l2_pkg::*;
#(
    parameter int L2_LINES = 16,
    parameter int IDX_W    = $clog2(L2_LINES),
    parameter int TAG_W    = ADDR_W - OFFS_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output line_t            rd_line,
    input  logic             line_we,
    input  logic             word_we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  line_t            wr_line,
    input  logic [1:0]       wr_word,
    input  word_t            wr_data
);

    logic [TAG_W-1:0]    tag_mem  [L2_LINES];
    line_t               data_mem [L2_LINES];
    logic [L2_LINES-1:0] valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < L2_LINES; gi++) begin : g_valid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (line_we && (wr_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end else if (word_we) begin
            data_mem[wr_idx][{wr_word, 5'b00000} +: WORD_W] <= wr_data;
        end
    end

    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];
    assign rd_valid = valid_reg[rd_idx];

endmodule

// File: rtl/l2_fill_ctrl.sv
// Direct-mapped write-through L2 between L1 and memory: 4-beat line fills, write forwarding.
// Define L2_STATS_EN to add the hit_cnt/miss_cnt read-statistics ports.
module l2_fill_ctrl
    import l2_pkg::*;
#(
    parameter int L2_LINES = 16
) (
    input  logic     clk,
    input  logic     rst,
    l2_l1_if.slave   l1,
    l2_mem_if.master mem
`ifdef L2_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDX_W = $clog2(L2_LINES);
    localparam int TAG_W = ADDR_W - OFFS_W - IDX_W;

    logic [1:0]        state_reg;
    logic [1:0]        beat_reg;
    logic [ADDR_W-1:0] addr_reg;
    line_t             buf_reg;
    line_t             l1block_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    word_t             mem_wdata_reg;

    logic [ADDR_W-1:0] look_addr;
    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    line_t             rd_line;
    logic              hit;
    line_t             fill_line;
    logic              beat_done;
    logic              line_we;
    logic              word_we;

    // In IDLE the live request is looked up; afterwards the latched address is,
    // so a request dropped mid-fill still installs into the right line.
    assign look_addr = (state_reg == ST_IDLE) ? l1.req_addr : addr_reg;
    assign look_idx  = IDX_W'(addr_idx(look_addr, IDX_W));
    assign look_tag  = TAG_W'(addr_tag(look_addr, IDX_W));
    assign hit       = rd_valid && (rd_tag == look_tag);

    always_comb begin
        fill_line = buf_reg;
        fill_line[{beat_reg, 5'b00000} +: WORD_W] = mem.mem_rdata;
    end

    assign beat_done = mem_req_reg && mem.mem_ack;
    assign line_we   = (state_reg == ST_FILL)  && beat_done && (beat_reg == 2'd3);
    assign word_we   = (state_reg == ST_WRITE) && beat_done && hit;

    l2_line_store #(
        .L2_LINES (L2_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (look_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_line  (rd_line),
        .line_we  (line_we),
        .word_we  (word_we),
        .wr_idx   (look_idx),
        .wr_tag   (look_tag),
        .wr_line  (fill_line),
        .wr_word  (addr_word(addr_reg)),
        .wr_data  (mem_wdata_reg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= 2'd0;
            addr_reg      <= '0;
            buf_reg       <= '0;
            l1block_reg   <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (l1.req_ren) begin
                        addr_reg <= l1.req_addr;
                        if (hit) begin
                            l1block_reg <= rd_line;
                            state_reg   <= ST_RESP;
                        end else begin
                            beat_reg     <= 2'd0;
                            mem_req_reg  <= 1'b1;
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= {l1.req_addr[ADDR_W-1:4], 4'b0000};
                            state_reg    <= ST_FILL;
                        end
                    end else if (l1.req_wen) begin
                        addr_reg      <= l1.req_addr;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= {l1.req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_reg <= l1.req_wdata;
                        state_reg     <= ST_WRITE;
                    end
                end
                ST_FILL: begin
                    if (beat_done) begin
                        buf_reg <= fill_line;
                        if (beat_reg == 2'd3) begin
                            l1block_reg <= fill_line;
                            mem_req_reg <= 1'b0;
                            state_reg   <= ST_RESP;
                        end else begin
                            beat_reg     <= beat_reg + 2'd1;
                            mem_addr_reg <= {addr_reg[ADDR_W-1:4], beat_reg + 2'd1, 2'b00};
                        end
                    end
                end
                ST_WRITE: begin
                    if (beat_done) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= ST_RESP;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef L2_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state_reg == ST_IDLE) && l1.req_ren) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

    // Combinational so the L1 is held in the very cycle it raises a request.
    assign l1.stall_l2   = (l1.req_ren | l1.req_wen) & (state_reg != ST_RESP);
    assign l1.l1block    = l1block_reg;
    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Directed bench for l2_fill_ctrl: cache/memory model, per-cycle beat and block checker.
module tb_l2_fill_ctrl;
    import l2_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_l1_if  l1();
    l2_mem_if mem();
`ifdef L2_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    l2_fill_ctrl #(.L2_LINES(16)) dut (
        .clk (clk),
        .rst (rst),
        .l1  (l1),
        .mem (mem)
`ifdef L2_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] mem_arr [logic [31:0]];
    int ack_delay = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else begin
                if (mem.mem_ack) begin
                    mem.mem_ack = 1'b0;
                    wait_cnt    = 0;
                end
                if (mem.mem_req) begin
                    if (wait_cnt >= ack_delay) begin
                        mem.mem_ack = 1'b1;
                        if (mem.mem_we) mem_arr[mem.mem_addr] = mem.mem_wdata;
                        else            mem.mem_rdata = mem_word(mem.mem_addr);
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- behavioural cache model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t       exp_q [$];
    logic        m_valid [16];
    logic [23:0] m_tag   [16];
    line_t       m_data  [16];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_read(input logic [31:0] a, output line_t blk, output logic hit);
        int          idx;
        logic [31:0] wa;
        idx = int'(a[7:4]);
        hit = m_valid[idx] && (m_tag[idx] == a[31:8]);
        blk = m_data[idx];
        if (hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            for (int k = 0; k < 4; k++) begin
                wa = {a[31:4], 4'b0000} + 32'(4 * k);
                exp_q.push_back('{wa, 1'b0, 32'd0});
                blk[32*k +: 32] = mem_word(wa);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:8];
            m_data[idx]  = blk;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a[7:4]);
        exp_q.push_back('{{a[31:2], 2'b00}, 1'b1, d});
        if (m_valid[idx] && (m_tag[idx] == a[31:8])) m_data[idx][32*int'(a[3:2]) +: 32] = d;
    endtask

    // ---------------- per-cycle compare process ----------------
    int    beats_seen = 0;
    line_t exp_block  = '0;
    logic  block_chk  = 1'b0;

    initial begin
        logic        prev_req, prev_ack, prev_we;
        logic [31:0] prev_addr, prev_wdata;
        beat_t       b;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_we  = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_req && !prev_ack)
                    check("beat_hold", {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata},
                          {1'b1, prev_we, prev_addr, prev_wdata});
                if (mem.mem_req && mem.mem_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {mem.mem_we, mem.mem_addr}, 128'd0);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat", {mem.mem_addr, mem.mem_we, mem.mem_we ? mem.mem_wdata : 32'd0},
                              {b.addr, b.we, b.wdata});
                    end
                    beats_seen++;
                end
                if (block_chk && l1.req_ren && !l1.stall_l2)
                    check("l1block", l1.l1block, exp_block);
                prev_req   = mem.mem_req;
                prev_ack   = mem.mem_ack;
                prev_we    = mem.mem_we;
                prev_addr  = mem.mem_addr;
                prev_wdata = mem.mem_wdata;
            end
        end
    end

    // ---------------- transactions ----------------
    task automatic wait_resp(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!l1.stall_l2) break;
            cyc++;
        end
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input int dly);
        line_t blk;
        logic  hit;
        int    cyc, b0;
        model_read(a, blk, hit);
        ack_delay  = dly;
        exp_block  = blk;
        block_chk  = 1'b1;
        b0         = beats_seen;
        l1.req_addr = a;
        l1.req_ren  = 1'b1;
        wait_resp(cyc);
        check({name, "_lat"}, 128'(cyc), hit ? 128'd1 : 128'(4 * (dly + 1) + 1));
        check({name, "_beats"}, 128'(beats_seen - b0), hit ? 128'd0 : 128'd4);
        $display("read  %h dly=%0d lat=%0d hit=%0d blk=%h", a, dly, cyc, hit, l1.l1block);
        @(posedge clk);
        #1;
        l1.req_ren = 1'b0;
        block_chk  = 1'b0;
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d, input int dly);
        int cyc, b0;
        model_write(a, d);
        ack_delay    = dly;
        b0           = beats_seen;
        l1.req_addr  = a;
        l1.req_wdata = d;
        l1.req_wen   = 1'b1;
        wait_resp(cyc);
        check({name, "_lat"}, 128'(cyc), 128'(dly + 2));
        check({name, "_beats"}, 128'(beats_seen - b0), 128'd1);
        $display("write %h data=%h dly=%0d lat=%0d", a, d, dly, cyc);
        @(posedge clk);
        #1;
        l1.req_wen = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_l1block"}, l1.l1block, 128'd0);
        check({name, "_memsig"}, {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata}, 128'd0);
`ifdef L2_STATS_EN
        check({name, "_cnt"}, {hit_cnt, miss_cnt}, 128'd0);
`endif
    endtask

    initial begin
        line_t blk;
        logic  hit;
        int    cyc, b0;

        l1.req_addr  = '0;
        l1.req_ren   = 1'b0;
        l1.req_wen   = 1'b0;
        l1.req_wdata = '0;
        model_reset();
        mem_arr[32'h40] = 32'd11;
        mem_arr[32'h44] = 32'd22;
        mem_arr[32'h48] = 32'd33;
        mem_arr[32'h4C] = 32'd44;
        for (int k = 0; k < 4; k++) mem_arr[32'h440 + 32'(4 * k)] = 32'h0440_0001 + 32'(k);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_stall", 128'(l1.stall_l2), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: cold read
        do_read("cold", 32'h40, 0);
        check("cold_lit", l1.l1block, {32'd11, 32'd22, 32'd33, 32'd44});
        // 2: hit on another word of the same line
        do_read("hit", 32'h48, 0);
        check("hit_lit", l1.l1block, {32'd11, 32'd22, 32'd33, 32'd44});
`ifdef L2_STATS_EN
        check("cnt_after_hit", {hit_cnt, miss_cnt}, {32'd1, 32'd1});
`endif
        // 3: write hit then read from the array
        do_write("whit", 32'h44, 32'hDEAD_BEEF, 0);
        do_read("rd_after_w", 32'h40, 0);
        check("whit_lit", l1.l1block, {32'd11, 32'hDEAD_BEEF, 32'd33, 32'd44});
        // 4: same index, different tag; then the evicted line misses again
        do_read("alias", 32'h440, 0);
        check("alias_lit", l1.l1block, {32'h0440_0001, 32'h0440_0002, 32'h0440_0003, 32'h0440_0004});
        do_read("reread", 32'h40, 0);
        check("reread_lit", l1.l1block, {32'd11, 32'hDEAD_BEEF, 32'd33, 32'd44});
        // 5: slow memory
        do_read("slow", 32'hC0, 3);
        // 7: read and write together; read first, write after RESP
        model_read(32'h104, blk, hit);
        model_write(32'h104, 32'hCAFE_F00D);
        ack_delay    = 0;
        exp_block    = blk;
        block_chk    = 1'b1;
        b0           = beats_seen;
        l1.req_addr  = 32'h104;
        l1.req_wdata = 32'hCAFE_F00D;
        l1.req_ren   = 1'b1;
        l1.req_wen   = 1'b1;
        wait_resp(cyc);
        check("rw_read_lat", 128'(cyc), 128'd5);
        check("rw_read_beats", 128'(beats_seen - b0), 128'd4);
        @(posedge clk);
        #1;
        l1.req_ren = 1'b0;
        block_chk  = 1'b0;
        b0         = beats_seen;
        wait_resp(cyc);
        check("rw_write_lat", 128'(cyc), 128'd2);
        check("rw_write_beats", 128'(beats_seen - b0), 128'd1);
        $display("rw    104 read then write lat=%0d", cyc);
        @(posedge clk);
        #1;
        l1.req_wen = 1'b0;
        do_read("rw_check", 32'h104, 0);
        check("rw_lit", {96'd0, l1.l1block[32:63]}, {96'd0, 32'hCAFE_F00D});
        // write miss: no allocate, memory still updated
        do_write("wmiss", 32'h204, 32'h1234_5678, 1);
        do_read("wmiss_rd", 32'h200, 0);
        check("wmiss_lit", {96'd0, l1.l1block[32:63]}, {96'd0, 32'h1234_5678});
`ifdef L2_STATS_EN
        check("cnt_final", {hit_cnt, miss_cnt}, {32'(exp_hits), 32'(exp_misses)});
`endif
        // 6: reset after beat 1 of a fill
        model_read(32'h80, blk, hit);
        ack_delay   = 2;
        b0          = beats_seen;
        l1.req_addr = 32'h80;
        l1.req_ren  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (beats_seen - b0 >= 2) break;
        end
        check("pre_rst_beats", 128'(beats_seen - b0), 128'd2);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        l1.req_ren = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("mid_fill_rst");
        $display("reset during fill at 80");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_read("after_rst", 32'h80, 0);
        do_read("after_rst_hit", 32'h84, 0);
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("model hits=%0d misses=%0d", exp_hits, exp_misses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
